// File: rtl/clause_eval_pkg.sv
// Shared types for the chunked clause evaluator: result encoding, FSM states
// and the saturating free-literal adder used when folding chunks together.
package clause_eval_pkg;

  typedef enum logic [1:0] {
    UNRESOLVED = 2'd0,
    UNIT       = 2'd1,
    SAT        = 2'd2,
    CONFLICT   = 2'd3
  } clause_result_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Free-literal counts only need to distinguish 0, 1 and "2 or more".
  function automatic logic [1:0] sat_add2(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum >= 3'd2) ? 2'd2 : sum[1:0];
  endfunction

  function automatic clause_result_t resolve(input logic any_true, input logic [1:0] free_cnt);
    if (any_true)              return SAT;
    else if (free_cnt == 2'd1) return UNIT;
    else if (free_cnt == 2'd2) return UNRESOLVED;
    else                       return CONFLICT;
  endfunction

endpackage

// File: rtl/chunk_lit_eval.sv
// Combinational view of one chunk: any true literal, saturating free-literal
// count, and the ID/pole of the lowest-slot free literal.
module chunk_lit_eval #(
  parameter int VAR_PER_CLAUSE = 5,
  parameter int NUM_VARIABLE   = 128,
  localparam int VAR_W         = $clog2(NUM_VARIABLE)
) (
  input  logic [VAR_PER_CLAUSE-1:0]            unassign,
  input  logic [VAR_PER_CLAUSE-1:0]            clause_mask,
  input  logic [VAR_PER_CLAUSE-1:0]            clause_pole,
  input  logic [VAR_PER_CLAUSE-1:0]            val,
  input  logic [VAR_PER_CLAUSE-1:0][VAR_W-1:0] variable,
  output logic                                 any_true,
  output logic [1:0]                           free_cnt,
  output logic [VAR_W-1:0]                     first_var,
  output logic                                 first_pole
);

  logic found;

  always_comb begin
    any_true   = 1'b0;
    free_cnt   = 2'd0;
    first_var  = '0;
    first_pole = 1'b0;
    found      = 1'b0;
    for (int i = 0; i < VAR_PER_CLAUSE; i++) begin
      if (clause_mask[i] && !unassign[i] && (val[i] ^ clause_pole[i])) begin
        any_true = 1'b1;
      end
      if (clause_mask[i] && unassign[i]) begin
        if (!found) begin
          first_var  = variable[i];
          first_pole = clause_pole[i];
          found      = 1'b1;
        end
        if (free_cnt != 2'd2) free_cnt = free_cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/wide_clause_eval.sv
// Evaluates a clause delivered as up to MAX_CHUNKS chunks of literal slots.
// Optional stat_units/stat_conflicts counters under WIDE_CLAUSE_EVAL_STATS_EN.
module wide_clause_eval
  import clause_eval_pkg::*;
#(
  parameter int VAR_PER_CLAUSE  = 5,
  parameter int NUM_VARIABLE    = 128,
  parameter int MAX_CHUNKS      = 4,
  localparam int VARIABLE_INDEX = $clog2(NUM_VARIABLE) - 1,
  localparam int CNT_W          = $clog2(MAX_CHUNKS + 1)
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic                                          in_last,
  input  logic [VAR_PER_CLAUSE-1:0]                     unassign,
  input  logic [VAR_PER_CLAUSE-1:0]                     clause_mask,
  input  logic [VAR_PER_CLAUSE-1:0]                     clause_pole,
  input  logic [VAR_PER_CLAUSE-1:0]                     val,
  input  logic [VAR_PER_CLAUSE-1:0][VARIABLE_INDEX:0]   variable,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output clause_result_t                                result,
  output logic [VARIABLE_INDEX:0]                       implied_variable,
  output logic                                          new_val,
  output logic                                          truncated,
  output state_t                                        state_dbg
`ifdef WIDE_CLAUSE_EVAL_STATS_EN
  ,
  output logic [15:0]                                   stat_units,
  output logic [15:0]                                   stat_conflicts
`endif
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high; in_ready/out_valid depend only on state, never on the partner's valid/ready.

  state_t                  state_q, state_d;
  logic                    any_true_q, any_true_d;
  logic [1:0]              free_cnt_q, free_cnt_d;
  logic [VARIABLE_INDEX:0] cap_var_q, cap_var_d;
  logic                    cap_pole_q, cap_pole_d;
  logic [CNT_W-1:0]        chunk_cnt_q, chunk_cnt_d;
  clause_result_t          result_q, result_d;
  logic [VARIABLE_INDEX:0] implied_q, implied_d;
  logic                    new_val_q, new_val_d;
  logic                    truncated_q, truncated_d;

  logic                    c_any_true;
  logic [1:0]              c_free_cnt;
  logic [VARIABLE_INDEX:0] c_first_var;
  logic                    c_first_pole;

  logic                    accept;
  logic                    base_any;
  logic [1:0]              base_free;
  logic                    m_any;
  logic [1:0]              m_free;
  logic [VARIABLE_INDEX:0] m_var;
  logic                    m_pole;
  logic [CNT_W-1:0]        cnt_inc;
  logic                    hit_max;
  clause_result_t          m_result;

  chunk_lit_eval #(
    .VAR_PER_CLAUSE (VAR_PER_CLAUSE),
    .NUM_VARIABLE   (NUM_VARIABLE)
  ) u_chunk (
    .unassign    (unassign),
    .clause_mask (clause_mask),
    .clause_pole (clause_pole),
    .val         (val),
    .variable    (variable),
    .any_true    (c_any_true),
    .free_cnt    (c_free_cnt),
    .first_var   (c_first_var),
    .first_pole  (c_first_pole)
  );

  always_comb begin
    accept    = in_valid && (state_q != DONE);
    // A chunk accepted in IDLE starts a fresh clause, so it folds into zeros.
    base_any  = (state_q == IDLE) ? 1'b0 : any_true_q;
    base_free = (state_q == IDLE) ? 2'd0 : free_cnt_q;
    m_any     = base_any | c_any_true;
    m_free    = sat_add2(base_free, c_free_cnt);
    m_var     = (base_free == 2'd0) ? c_first_var  : cap_var_q;
    m_pole    = (base_free == 2'd0) ? c_first_pole : cap_pole_q;
    cnt_inc   = (state_q == IDLE) ? CNT_W'(1) : chunk_cnt_q + CNT_W'(1);
    hit_max   = (cnt_inc == CNT_W'(MAX_CHUNKS));
    m_result  = resolve(m_any, m_free);

    state_d     = state_q;
    any_true_d  = any_true_q;
    free_cnt_d  = free_cnt_q;
    cap_var_d   = cap_var_q;
    cap_pole_d  = cap_pole_q;
    chunk_cnt_d = chunk_cnt_q;
    result_d    = result_q;
    implied_d   = implied_q;
    new_val_d   = new_val_q;
    truncated_d = truncated_q;

    case (state_q)
      IDLE, SCAN: begin
        if (accept) begin
          any_true_d  = m_any;
          free_cnt_d  = m_free;
          cap_var_d   = m_var;
          cap_pole_d  = m_pole;
          chunk_cnt_d = cnt_inc;
          if (in_last || hit_max) begin
            state_d     = DONE;
            chunk_cnt_d = '0;
            result_d    = m_result;
            implied_d   = (m_result == UNIT) ? m_var   : '0;
            new_val_d   = (m_result == UNIT) ? ~m_pole : 1'b0;
            truncated_d = hit_max && !in_last;
          end else begin
            state_d = SCAN;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      any_true_q  <= 1'b0;
      free_cnt_q  <= 2'd0;
      cap_var_q   <= '0;
      cap_pole_q  <= 1'b0;
      chunk_cnt_q <= '0;
      result_q    <= UNRESOLVED;
      implied_q   <= '0;
      new_val_q   <= 1'b0;
      truncated_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      any_true_q  <= any_true_d;
      free_cnt_q  <= free_cnt_d;
      cap_var_q   <= cap_var_d;
      cap_pole_q  <= cap_pole_d;
      chunk_cnt_q <= chunk_cnt_d;
      result_q    <= result_d;
      implied_q   <= implied_d;
      new_val_q   <= new_val_d;
      truncated_q <= truncated_d;
    end
  end

  assign in_ready         = (state_q != DONE);
  assign out_valid        = (state_q == DONE);
  assign result           = result_q;
  assign implied_variable = implied_q;
  assign new_val          = new_val_q;
  assign truncated        = truncated_q;
  assign state_dbg        = state_q;

`ifdef WIDE_CLAUSE_EVAL_STATS_EN
  logic [15:0] stat_units_q, stat_units_d;
  logic [15:0] stat_conflicts_q, stat_conflicts_d;
  logic        out_fire;

  always_comb begin
    out_fire         = (state_q == DONE) && out_ready;
    stat_units_d     = stat_units_q;
    stat_conflicts_d = stat_conflicts_q;
    if (out_fire && result_q == UNIT && stat_units_q != 16'hFFFF)
      stat_units_d = stat_units_q + 16'd1;
    if (out_fire && result_q == CONFLICT && stat_conflicts_q != 16'hFFFF)
      stat_conflicts_d = stat_conflicts_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stat_units_q     <= '0;
      stat_conflicts_q <= '0;
    end else begin
      stat_units_q     <= stat_units_d;
      stat_conflicts_q <= stat_conflicts_d;
    end
  end

  assign stat_units     = stat_units_q;
  assign stat_conflicts = stat_conflicts_q;
`endif

endmodule

// File: tb/tb_wide_clause_eval.sv
// Directed bench for wide_clause_eval: drivers issue chunks and push expected
// results; a monitor pops and compares on every output handshake.
module tb_wide_clause_eval;
  import clause_eval_pkg::*;

  localparam int VPC = 5;
  localparam int NV  = 128;
  localparam int MC  = 4;
  localparam int VW  = 7;
  localparam int W   = 2 + VW + 2;

  logic                     clock = 1'b0;
  logic                     reset;
  logic                     in_valid;
  logic                     in_ready;
  logic                     in_last;
  logic [VPC-1:0]           unassign;
  logic [VPC-1:0]           clause_mask;
  logic [VPC-1:0]           clause_pole;
  logic [VPC-1:0]           val;
  logic [VPC-1:0][VW-1:0]   variable;
  logic                     out_valid;
  logic                     out_ready;
  clause_result_t           result;
  logic [VW-1:0]            implied_variable;
  logic                     new_val;
  logic                     truncated;
  state_t                   state_dbg;
`ifdef WIDE_CLAUSE_EVAL_STATS_EN
  logic [15:0]              stat_units;
  logic [15:0]              stat_conflicts;
`endif

  logic [W-1:0]             exp_q[$];
  logic [W-1:0]             mon_exp;
  int                       pass_cnt = 0;
  int                       total_cnt = 0;
  int                       exp_units = 0;
  int                       exp_conflicts = 0;
  logic [VPC-1:0][VW-1:0]   vs;

  wide_clause_eval #(
    .VAR_PER_CLAUSE (VPC),
    .NUM_VARIABLE   (NV),
    .MAX_CHUNKS     (MC)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_last          (in_last),
    .unassign         (unassign),
    .clause_mask      (clause_mask),
    .clause_pole      (clause_pole),
    .val              (val),
    .variable         (variable),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .result           (result),
    .implied_variable (implied_variable),
    .new_val          (new_val),
    .truncated        (truncated),
    .state_dbg        (state_dbg)
`ifdef WIDE_CLAUSE_EVAL_STATS_EN
    ,
    .stat_units       (stat_units),
    .stat_conflicts   (stat_conflicts)
`endif
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_result: got %0h expected none",
                 {result, implied_variable, new_val, truncated});
      end else begin
        mon_exp = exp_q.pop_front();
        check("result_pkt", 32'({result, implied_variable, new_val, truncated}), 32'(mon_exp));
      end
    end
  end

  task automatic expect_result(input logic [1:0] res, input logic [VW-1:0] id,
                               input logic nv, input logic tr);
    exp_q.push_back({res, id, nv, tr});
    if (res == 2'(UNIT))     exp_units++;
    if (res == 2'(CONFLICT)) exp_conflicts++;
  endtask

  function automatic logic [VPC-1:0][VW-1:0] rand_vars();
    logic [VPC-1:0][VW-1:0] r;
    for (int i = 0; i < VPC; i++) r[i] = VW'($urandom_range(0, NV - 1));
    return r;
  endfunction

  task automatic scramble_inputs();
    unassign    = VPC'($urandom_range(0, 31));
    clause_mask = VPC'($urandom_range(0, 31));
    clause_pole = VPC'($urandom_range(0, 31));
    val         = VPC'($urandom_range(0, 31));
    variable    = rand_vars();
  endtask

  // Drive one chunk and return at #1 after the edge where it was accepted.
  task automatic send_chunk(input logic [VPC-1:0] m, input logic [VPC-1:0] u,
                            input logic [VPC-1:0] p, input logic [VPC-1:0] v,
                            input logic [VPC-1:0][VW-1:0] vars, input logic last);
    int n;
    @(negedge clock);
    clause_mask = m; unassign = u; clause_pole = p; val = v;
    variable = vars; in_last = last; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      total_cnt++;
      $display("FAIL chunk_accept_timeout: in_ready=%0b expected 1", in_ready);
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    scramble_inputs();
  endtask

  task automatic send_false(input logic last);
    send_chunk(5'b11111, 5'b00000, 5'b00000, 5'b00000, rand_vars(), last);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      total_cnt++;
      $display("FAIL drain_timeout: pending=%0d expected 0", exp_q.size());
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    scramble_inputs();
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_in_ready",  32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result",    32'(result), 32'(UNRESOLVED));
    check("rst_implied",   32'(implied_variable), 32'd0);
    check("rst_new_val",   32'(new_val), 32'd0);
    check("rst_truncated", 32'(truncated), 32'd0);
    check("rst_state",     32'(state_dbg), 32'(IDLE));

    // single-chunk UNIT on slot 4
    expect_result(2'(UNIT), 7'd37, 1'b1, 1'b0);
    vs = rand_vars(); vs[4] = 7'd37;
    send_chunk(5'b11111, 5'b10000, 5'b00000, 5'b00000, vs, 1'b1);
    check("unit1_latency", 32'(out_valid), 32'd1);

    // two-chunk UNIT, negated free literal
    expect_result(2'(UNIT), 7'd90, 1'b0, 1'b0);
    send_false(1'b0);
    check("unit2_mid_valid", 32'(out_valid), 32'd0);
    vs = rand_vars(); vs[0] = 7'd90;
    send_chunk(5'b11111, 5'b00001, 5'b00001, 5'b00000, vs, 1'b1);
    check("unit2_latency", 32'(out_valid), 32'd1);

    // three chunks, two free literals -> UNRESOLVED
    expect_result(2'(UNRESOLVED), 7'd0, 1'b0, 1'b0);
    vs = rand_vars(); vs[2] = 7'd11;
    send_chunk(5'b11111, 5'b00100, 5'b00000, 5'b00000, vs, 1'b0);
    send_false(1'b0);
    vs = rand_vars(); vs[3] = 7'd22;
    send_chunk(5'b11111, 5'b01000, 5'b00000, 5'b00000, vs, 1'b1);

    // same but a true literal in the middle chunk -> SAT
    expect_result(2'(SAT), 7'd0, 1'b0, 1'b0);
    vs = rand_vars(); vs[2] = 7'd11;
    send_chunk(5'b11111, 5'b00100, 5'b00000, 5'b00000, vs, 1'b0);
    send_chunk(5'b11111, 5'b00000, 5'b00000, 5'b00010, rand_vars(), 1'b0);
    vs = rand_vars(); vs[3] = 7'd22;
    send_chunk(5'b11111, 5'b01000, 5'b00000, 5'b00000, vs, 1'b1);

    // all false over two chunks -> CONFLICT
    expect_result(2'(CONFLICT), 7'd0, 1'b0, 1'b0);
    send_false(1'b0);
    send_false(1'b1);

    // empty mask -> CONFLICT, with out_ready held low for 5 cycles
    wait_drain();
    out_ready = 1'b0;
    expect_result(2'(CONFLICT), 7'd0, 1'b0, 1'b0);
    send_chunk(5'b00000, 5'b11111, 5'b10101, 5'b11111, rand_vars(), 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready",  32'(in_ready), 32'd0);
      check("stall_outputs",   32'({result, implied_variable, new_val, truncated}),
                               32'({CONFLICT, 7'd0, 1'b0, 1'b0}));
    end
    @(posedge clock);
    #1 out_ready = 1'b1;

    // four chunks without in_last -> forced end with truncated
    expect_result(2'(UNIT), 7'd55, 1'b0, 1'b1);
    send_false(1'b0);
    send_false(1'b0);
    vs = rand_vars(); vs[2] = 7'd55;
    send_chunk(5'b11111, 5'b00100, 5'b00100, 5'b00000, vs, 1'b0);
    check("trunc_mid_valid", 32'(out_valid), 32'd0);
    send_false(1'b0);
    check("trunc_latency", 32'(out_valid), 32'd1);
    check("trunc_flag", 32'(truncated), 32'd1);
    // fifth chunk opens a fresh clause
    expect_result(2'(UNIT), 7'd3, 1'b1, 1'b0);
    vs = rand_vars(); vs[0] = 7'd3;
    send_chunk(5'b11111, 5'b00001, 5'b00000, 5'b00000, vs, 1'b0);
    check("trunc_next_scan", 32'(state_dbg), 32'(SCAN));
    send_false(1'b1);

    // reset mid-SCAN, with a last chunk offered in the reset cycle
    wait_drain();
    send_chunk(5'b11111, 5'b00000, 5'b00000, 5'b00001, rand_vars(), 1'b0);
    send_false(1'b0);
    @(negedge clock);
    reset = 1'b1; in_valid = 1'b1; in_last = 1'b1;
    clause_mask = 5'b11111; unassign = 5'b00001; clause_pole = 5'b0; val = 5'b0;
    @(posedge clock);
    #1 reset = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    @(negedge clock);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready",  32'(in_ready), 32'd1);
    check("mid_rst_state",     32'(state_dbg), 32'(IDLE));
    check("mid_rst_outputs",   32'({result, implied_variable, new_val, truncated}),
                               32'({UNRESOLVED, 7'd0, 1'b0, 1'b0}));
    expect_result(2'(UNIT), 7'd44, 1'b0, 1'b0);
    vs = rand_vars(); vs[1] = 7'd44;
    send_chunk(5'b11111, 5'b00010, 5'b00010, 5'b00000, vs, 1'b1);
    check("post_rst_latency", 32'(out_valid), 32'd1);

    wait_drain();
    repeat (2) @(posedge clock);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
`ifdef WIDE_CLAUSE_EVAL_STATS_EN
    check("stat_units",     32'(stat_units), 32'(exp_units));
    check("stat_conflicts", 32'(stat_conflicts), 32'(exp_conflicts));
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: sim time exceeded");
    $fatal(1, "timeout");
  end

endmodule
